tiny_dnn_core_fx: RTL and testbench
===================================

TINY_DNN_CORE_FX -- requirements
Module: tiny_dnn_core_fx

Interface
REQ-001 Parameters SHALL be: LANES, default 4, number of parallel neurons; DEPTH, default 1024, weight words per lane (last word is bias); DW, default 16, signed data/weight width; FRAC, default 8, fraction bits of data/weight; ACCW, default 40, accumulator width; AW, default $clog2(DEPTH), address width.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init  in  1  clear the accumulator selected by sum_ip in every lane.
REQ-005 write  in  1  write wd into weight memory of lane wl.
REQ-006 bwrite  in  1  redirect a write to address DEPTH-1.
REQ-007 exec  in  1  issue multiply-accumulate at address ra with input d.
REQ-008 bias  in  1  issue bias add from address DEPTH-1.
REQ-009 sum_ip  in  1  accumulator bank updated by issued operations.
REQ-010 sum_op  in  1  accumulator bank presented on sum.
REQ-011 relu  in  1  clamp negative outputs to zero.
REQ-012 ra, wa  in  AW  read/write address.
REQ-013 wl  in  $clog2(LANES)  target lane for write.
REQ-014 d  in  DW  signed Q(DW-FRAC).FRAC input, broadcast to all lanes.
REQ-015 wd  in  DW  signed write data.
REQ-016 sum  out  LANES*DW  per-lane saturated, optionally rectified, result; lane i at bits [i*DW +: DW].
REQ-017 ovf  out  LANES  sticky per-lane accumulator overflow flag.
REQ-018 busy  out  1  high while any issued operation is in the pipeline.

Function
REQ-019 Pipeline SHALL be 3 stages: S0 registers weight read, S1 registers weight and d, S2 updates accumulator; an operation issued in cycle t SHALL be visible on sum (sum_op equal to its sum_ip) in cycle t+3.
REQ-020 sum_ip and control SHALL be carried down the pipeline with each operation, so changing sum_ip mid-stream does not misroute in-flight operations.
REQ-021 init SHALL be delayed 2 cycles and clear the bank selected at issue.
REQ-022 exec SHALL add sign-extended (w*d)>>>FRAC, arithmetic shift with truncation toward minus infinity, to the accumulator.
REQ-023 bias SHALL add w<<<0 aligned to FRAC, i.e. sign-extended w, to the accumulator; bias has priority over ra when both exec and bias are high, and the operation is treated as bias.
REQ-024 init together with exec/bias in the same issue cycle SHALL load the accumulator with that single contribution (clear then add).
REQ-025 Accumulator addition SHALL be ACCW-bit two's-complement wrapping; signed overflow SHALL set ovf[lane] until init of that lane's bank or reset.
REQ-026 sum SHALL be the selected accumulator saturated to [-2^(DW-1), 2^(DW-1)-1], then, if relu, negative values forced to 0; sum is combinational from accumulator, sum_op and relu.
REQ-027 Write and read of the same address in the same cycle SHALL return old data to the read.
REQ-028 write with wl >= LANES SHALL be ignored.
REQ-029 Both banks SHALL be independent: updates to bank sum_ip never alter bank !sum_ip (double buffering).
REQ-030 busy SHALL be OR of pipeline valid bits for exec, bias and init.

Reset
REQ-031 rst_n low SHALL asynchronously clear all pipeline valid bits, both accumulator banks of every lane, ovf and busy; sum reads 0.
REQ-032 Weight memories SHALL NOT be reset; contents are retained across reset.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none complete after rst_n rises.

Structure
REQ-034 A package tiny_dnn_pkg SHALL hold default parameter constants and the op typedef (enum NONE, INIT, MAC, BIAS) with pipeline-stage struct.
REQ-035 One sub-module tiny_dnn_lane SHALL implement one lane (memory, datapath, two accumulators, ovf); tiny_dnn_core_fx SHALL instantiate LANES of them and share control pipeline.

Verification
REQ-036 Write lane0 addr0..2 = 1.0,2.0,-1.0 (256,512,-256), init, exec d=1.0 three addresses -> sum lane0 = 512 (2.0) at issue+3 of last op.
REQ-037 Bias write 0.5 (128) via bwrite, init, bias -> sum = 128; with init+bias same cycle -> 128, no prior residue.
REQ-038 Accumulate 2^(DW-1) positive steps -> sum saturates at 32767; relu=1 with accumulated -300 -> sum 0, relu=0 -> -300.
REQ-039 Fill bank1 while sum_op=0 shows bank0 = 1000 unchanged; toggle sum_ip mid-stream -> in-flight ops land in issue bank.
REQ-040 Accumulator pushed past 2^(ACCW-1)-1 -> ovf[lane]=1, held until init of that bank.
REQ-041 Assert rst_n low 1 cycle after exec issue -> no update after release, sum=0, busy=0, weights unchanged.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// rtl/tiny_dnn_pkg.sv - shared constants and pipeline types for tiny_dnn_core_fx
package tiny_dnn_pkg;

    localparam int LANES_DEF = 4;
    localparam int DEPTH_DEF = 1024;
    localparam int DW_DEF    = 16;
    localparam int FRAC_DEF  = 8;
    localparam int ACCW_DEF  = 40;

    typedef enum logic [1:0] {NONE, INIT, MAC, BIAS} op_t;

    // Control that travels with each operation: what to do, whether to clear first, which bank
    typedef struct packed {
        op_t  op;
        logic clr;
        logic bank;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{op: NONE, clr: 1'b0, bank: 1'b0};

endpackage

// File: rtl/tiny_dnn_lane.sv
// rtl/tiny_dnn_lane.sv - one neuron lane: weight memory, MAC datapath, two accumulator banks
module tiny_dnn_lane
    import tiny_dnn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACCW  = ACCW_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wd,
    input  logic [AW-1:0]        raddr,
    input  stage_t               s1,
    input  logic signed [DW-1:0] d1,
    input  logic                 sum_op,
    input  logic                 relu,
    output logic [DW-1:0]        sum,
    output logic                 ovf
);

    logic signed [DW-1:0]   mem [DEPTH];
    logic signed [DW-1:0]   w0;
    logic signed [DW-1:0]   w1;
    logic signed [ACCW-1:0] acc [2];
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] contrib;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] nxt;
    logic signed [ACCW-1:0] sel;
    logic                   ovf_now;
    logic                   fits;
    logic [DW-1:0]          sat;

    // Weight storage keeps its contents through reset; the read register sees pre-write data
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wd;
        end
        w0 <= mem[raddr];
        w1 <= w0;
    end

    // Contribution of the operation in S2: scaled product or raw bias, onto an optionally cleared bank
    always_comb begin
        prod    = (2*DW)'(w1) * (2*DW)'(d1);
        contrib = (s1.op == BIAS) ? ACCW'(w1) : ACCW'(prod >>> FRAC);
        base    = s1.clr ? '0 : acc[s1.bank];
        nxt     = base + contrib;
        ovf_now = (base[ACCW-1] == contrib[ACCW-1]) && (nxt[ACCW-1] != base[ACCW-1]);
    end

    // Accumulator banks and sticky overflow, updated as each operation leaves the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc[0] <= '0;
            acc[1] <= '0;
            ovf    <= 1'b0;
        end else begin
            case (s1.op)
                INIT: begin
                    acc[s1.bank] <= '0;
                    ovf          <= 1'b0;
                end
                MAC, BIAS: begin
                    acc[s1.bank] <= nxt;
                    ovf          <= (ovf && !s1.clr) || ovf_now;
                end
                default: ;
            endcase
        end
    end

    // Present the selected bank saturated to DW bits, negatives zeroed when relu is set
    always_comb begin
        sel  = acc[sum_op];
        fits = (&sel[ACCW-1:DW-1]) || !(|sel[ACCW-1:DW-1]);
        if (fits) begin
            sat = sel[DW-1:0];
        end else if (sel[ACCW-1]) begin
            sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DW-1){1'b1}}};
        end
        sum = (relu && sat[DW-1]) ? '0 : sat;
    end

endmodule

// File: rtl/tiny_dnn_core_fx.sv
// rtl/tiny_dnn_core_fx.sv - multi-lane fixed-point neuron core with shared control pipeline
module tiny_dnn_core_fx
    import tiny_dnn_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DW     = DW_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ACCW   = ACCW_DEF,
    parameter int AW     = $clog2(DEPTH),
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 write,
    input  logic                 bwrite,
    input  logic                 exec,
    input  logic                 bias,
    input  logic                 sum_ip,
    input  logic                 sum_op,
    input  logic                 relu,
    input  logic [AW-1:0]        ra,
    input  logic [AW-1:0]        wa,
    input  logic [LW-1:0]        wl,
    input  logic signed [DW-1:0] d,
    input  logic signed [DW-1:0] wd,
    output logic [LANES*DW-1:0]  sum,
    output logic [LANES-1:0]     ovf,
    output logic                 busy
);

    localparam logic [AW-1:0] BIAS_ADDR = AW'(DEPTH - 1);

    stage_t               iss;
    stage_t               s0;
    stage_t               s1;
    logic signed [DW-1:0] d0;
    logic signed [DW-1:0] d1;
    logic [AW-1:0]        raddr;
    logic [AW-1:0]        waddr;

    assign raddr = bias   ? BIAS_ADDR : ra;
    assign waddr = bwrite ? BIAS_ADDR : wa;

    // Fold the issue-cycle controls into one operation; bias takes precedence over exec
    always_comb begin
        iss      = STAGE_IDLE;
        iss.clr  = init;
        iss.bank = sum_ip;
        if (bias) begin
            iss.op = BIAS;
        end else if (exec) begin
            iss.op = MAC;
        end else if (init) begin
            iss.op = INIT;
        end
    end

    // Control and input data ride alongside the lane weight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= STAGE_IDLE;
            s1 <= STAGE_IDLE;
            d0 <= '0;
            d1 <= '0;
        end else begin
            s0 <= iss;
            s1 <= s0;
            d0 <= d;
            d1 <= d0;
        end
    end

    assign busy = (s0.op != NONE) || (s1.op != NONE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tiny_dnn_lane #(
            .DEPTH (DEPTH),
            .DW    (DW),
            .FRAC  (FRAC),
            .ACCW  (ACCW),
            .AW    (AW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (write && (int'(wl) == i)),
            .waddr  (waddr),
            .wd     (wd),
            .raddr  (raddr),
            .s1     (s1),
            .d1     (d1),
            .sum_op (sum_op),
            .relu   (relu),
            .sum    (sum[i*DW +: DW]),
            .ovf    (ovf[i])
        );
    end

endmodule

// File: tb/tb_tiny_dnn_core_fx.sv
// tb/tb_tiny_dnn_core_fx.sv - directed and randomized check of tiny_dnn_core_fx against a queue model
module tb_tiny_dnn_core_fx;

    localparam int LANES = 4;
    localparam int DEPTH = 1024;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACCW  = 24;
    localparam int AW    = 10;
    localparam int LW    = 2;
    localparam int NW    = 16;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b1;
    logic                 init   = 1'b0;
    logic                 write  = 1'b0;
    logic                 bwrite = 1'b0;
    logic                 exec   = 1'b0;
    logic                 bias   = 1'b0;
    logic                 sum_ip = 1'b0;
    logic                 sum_op = 1'b0;
    logic                 relu   = 1'b0;
    logic [AW-1:0]        ra     = '0;
    logic [AW-1:0]        wa     = '0;
    logic [LW-1:0]        wl     = '0;
    logic signed [DW-1:0] d      = '0;
    logic signed [DW-1:0] wd     = '0;
    logic [LANES*DW-1:0]  sum;
    logic [LANES-1:0]     ovf;
    logic                 busy;

    always #5 clk = ~clk;

    tiny_dnn_core_fx #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .DW    (DW),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (init),
        .write  (write),
        .bwrite (bwrite),
        .exec   (exec),
        .bias   (bias),
        .sum_ip (sum_ip),
        .sum_op (sum_op),
        .relu   (relu),
        .ra     (ra),
        .wa     (wa),
        .wl     (wl),
        .d      (d),
        .wd     (wd),
        .sum    (sum),
        .ovf    (ovf),
        .busy   (busy)
    );

    typedef struct packed {
        logic [31:0]            due;
        logic                   clr;
        logic                   add;
        logic                   bank;
        logic [LANES-1:0][63:0] c;
    } pend_t;

    int     mem_m [LANES][DEPTH];
    longint acc_m [LANES][2];
    bit     ovf_m [LANES];
    pend_t  pq[$];
    int     cyc_n  = 0;
    int     n_chk  = 0;
    int     n_fail = 0;

    function automatic void apply(input pend_t e);
        longint lim;
        longint s;
        lim = longint'(1) << (ACCW - 1);
        for (int l = 0; l < LANES; l++) begin
            if (e.clr) begin
                acc_m[l][e.bank] = 0;
                ovf_m[l] = 0;
            end
            if (e.add) begin
                s = acc_m[l][e.bank] + longint'(e.c[l]);
                if (s >= lim) begin
                    s = s - 2 * lim;
                    ovf_m[l] = 1;
                end else if (s < -lim) begin
                    s = s + 2 * lim;
                    ovf_m[l] = 1;
                end
                acc_m[l][e.bank] = s;
            end
        end
    endfunction

    function automatic logic [DW-1:0] exp_sum(input longint a, input bit r);
        longint s;
        s = a;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (r && s < 0) s = 0;
        return DW'(s);
    endfunction

    task automatic model_reset();
        pq.delete();
        for (int l = 0; l < LANES; l++) begin
            acc_m[l][0] = 0;
            acc_m[l][1] = 0;
            ovf_m[l] = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        while (pq.size() > 0 && int'(pq[0].due) <= cyc_n) apply(pq.pop_front());
        #1;
    endtask

    task automatic step(input bit i_init, input bit i_exec, input bit i_bias, input bit i_sip,
                        input int i_ra, input int i_d, input bit i_wr, input bit i_bw,
                        input int i_wl, input int i_wa, input int i_wd);
        pend_t  e;
        longint w;
        init = i_init; exec = i_exec; bias = i_bias; sum_ip = i_sip;
        ra = AW'(i_ra); d = DW'(i_d);
        write = i_wr; bwrite = i_bw; wl = LW'(i_wl); wa = AW'(i_wa); wd = DW'(i_wd);
        if (i_init || i_exec || i_bias) begin
            e      = '0;
            e.due  = 32'(cyc_n + 3);
            e.clr  = i_init;
            e.add  = i_exec || i_bias;
            e.bank = i_sip;
            for (int l = 0; l < LANES; l++) begin
                w = i_bias ? longint'(mem_m[l][DEPTH-1]) : longint'(mem_m[l][i_ra]);
                if (i_bias) e.c[l] = w;
                else        e.c[l] = (w * longint'(d)) >>> FRAC;
            end
            pq.push_back(e);
        end
        if (i_wr && i_wl < LANES) mem_m[i_wl][i_bw ? DEPTH-1 : i_wa] = int'(wd);
        cyc();
        init = 0; exec = 0; bias = 0; write = 0; bwrite = 0;
    endtask

    task automatic wr(input int l, input int a, input int v);
        step(0, 0, 0, 0, 0, 0, 1, 0, l, a, v);
    endtask

    task automatic bw(input int l, input int v);
        step(0, 0, 0, 0, 0, 0, 1, 1, l, 0, v);
    endtask

    task automatic op(input bit i, input bit e, input bit b, input bit s, input int a, input int dd);
        step(i, e, b, s, a, dd, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && pq.size() != 0; k++) cyc();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_lane(input string tag, input int l, input int v);
        logic [DW-1:0] ev;
        ev = DW'(v);
        chk(tag, 64'(sum[l*DW +: DW]), 64'(ev));
    endtask

    task automatic chk_all(input string tag);
        logic [LANES-1:0] eo;
        for (int l = 0; l < LANES; l++) begin
            eo[l] = ovf_m[l];
            chk($sformatf("%s sum%0d", tag, l), 64'(sum[l*DW +: DW]), 64'(exp_sum(acc_m[l][sum_op], relu)));
        end
        chk({tag, " ovf"}, 64'(ovf), 64'(eo));
        chk({tag, " busy"}, 64'(busy), 64'(pq.size() != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        chk_all("reset bank0");
        sum_op = 1'b1; #1;
        chk_all("reset bank1");
        sum_op = 1'b0;

        // zero the weights that will be read, while still in reset
        for (int l = 0; l < LANES; l++) begin
            for (int a = 0; a < NW; a++) wr(l, a, 0);
            bw(l, 0);
        end
        rst_n = 1'b1;
        cyc();

        // 1.0, 2.0, -1.0 times d=1.0, with exact latency
        wr(0, 0, 256); wr(0, 1, 512); wr(0, 2, -256);
        op(1, 0, 0, 0, 0, 0);
        op(0, 1, 0, 0, 0, 256);
        op(0, 1, 0, 0, 1, 256);
        op(0, 1, 0, 0, 2, 256);
        chk_lane("mac t+1", 0, 256);
        cyc();
        chk_lane("mac t+2", 0, 768);
        cyc();
        chk_lane("mac t+3", 0, 512);
        chk_all("mac");

        // bias path, init+bias, and bias priority over exec
        bw(0, 128);
        op(1, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0);
        drain();
        chk_lane("bias", 0, 128);
        op(1, 0, 1, 0, 0, 0);
        drain();
        chk_lane("init+bias", 0, 128);
        op(0, 1, 1, 0, 1, 256);
        drain();
        chk_lane("bias wins", 0, 256);
        chk_all("bias");

        // saturation, truncation toward -inf, relu
        wr(1, 3, 32512); wr(2, 4, -300); wr(3, 5, 1);
        op(1, 1, 0, 0, 3, 32512);
        op(0, 1, 0, 0, 4, 256);
        op(0, 1, 0, 0, 5, -1);
        drain();
        chk_lane("sat pos", 1, 32767);
        chk_lane("relu off", 2, -300);
        chk_lane("trunc", 3, -1);
        relu = 1'b1; #1;
        chk_lane("relu on", 2, 0);
        chk_lane("relu pos", 1, 32767);
        chk_all("relu");
        relu = 1'b0;
        op(0, 1, 0, 0, 3, -32768);
        op(0, 1, 0, 0, 3, -32768);
        drain();
        chk_lane("sat neg", 1, -32768);
        chk_all("sat");

        // double buffering and mid-stream bank switching
        wr(0, 6, 1000);
        op(1, 1, 0, 0, 6, 256);
        drain();
        for (int k = 0; k < 4; k++) begin
            op(k == 0, 1, 0, 1, k % 3, 256);
            chk_lane("bank0 held", 0, 1000);
        end
        op(0, 1, 0, 0, 0, 256);
        op(0, 1, 0, 1, 1, 256);
        op(0, 1, 0, 0, 2, 256);
        drain();
        chk_lane("bank0 final", 0, 1000);
        chk_all("bank0");
        sum_op = 1'b1; #1;
        chk_lane("bank1 final", 0, 1280);
        chk_all("bank1");
        sum_op = 1'b0;

        // accumulator overflow is sticky until init
        op(1, 1, 0, 0, 3, 32512);
        op(0, 1, 0, 0, 3, 32512);
        op(0, 1, 0, 0, 3, 32512);
        drain();
        chk("ovf set", 64'(ovf), 64'(4'b0010));
        op(0, 1, 0, 1, 3, 256);
        drain();
        chk("ovf held", 64'(ovf), 64'(4'b0010));
        chk_all("ovf");
        op(1, 0, 0, 0, 0, 0);
        drain();
        chk("ovf clear", 64'(ovf), 64'(4'b0000));

        // reset one cycle after issue discards the operation
        op(1, 0, 0, 0, 0, 0);
        drain();
        op(0, 1, 0, 0, 0, 256);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("rst sum", 64'(sum), 64'(0));
        chk_all("post rst");
        sum_op = 1'b1; #1;
        chk_all("post rst bank1");
        sum_op = 1'b0;
        op(1, 1, 0, 0, 0, 256);
        drain();
        chk_lane("weights kept", 0, 256);

        // randomized traffic, checked every cycle
        for (int it = 0; it < 400; it++) begin
            bit ri, re, rb, rw, rbw;
            ri  = ($urandom_range(0, 7) == 0);
            re  = ($urandom_range(0, 1) == 1);
            rb  = ($urandom_range(0, 5) == 0);
            rw  = ($urandom_range(0, 2) == 0);
            rbw = ($urandom_range(0, 7) == 0);
            sum_op = 1'($urandom_range(0, 1));
            relu   = 1'($urandom_range(0, 1));
            step(ri, re, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, NW-1)),
                 int'($urandom_range(0, 1023)) - 512, rw, rbw, int'($urandom_range(0, LANES-1)),
                 int'($urandom_range(0, NW-1)), int'($urandom_range(0, 8191)) - 4096);
            chk_all("rand");
        end
        drain();
        chk_all("rand end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
